// File: rtl/ws2811_pkg.sv
// Shared types and constants for the WS2811 receiver.
//   rx_state_e : receiver FSM states
//   PIX_W      : bits per GRB pixel
//   BIT_TICKS, T0H, T1H : transmitter bit timing in clock cycles (bit period,
//                         high time of a "0", high time of a "1")
//   BC_W       : width of the per-pixel bit counter
package ws2811_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    HIGH = 2'd2
  } rx_state_e;

  localparam int PIX_W     = 24;
  localparam int BIT_TICKS = 16;
  localparam int T0H       = 4;
  localparam int T1H       = 9;
  localparam int BC_W      = $clog2(PIX_W);

endpackage

// File: rtl/ws2811_pulse_meas.sv
// Line front end for the WS2811 receiver: two-flop synchronizer, edge detect
// and a saturating timer that restarts on every line edge.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : raw serial line (asynchronous to clk)
//   din_s      : synchronized line level
//   rise, fall : single-cycle edge strobes of din_s
//   timer      : cycles since the last edge, minus one (saturating)
//   width      : cycles the current level has held before this one
//                (timer + 1, saturating); at a fall this is the pulse width
module ws2811_pulse_meas #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          din,
  output logic          din_s,
  output logic          rise,
  output logic          fall,
  output logic [CW-1:0] timer,
  output logic [CW-1:0] width
);

  logic          din_meta_q, din_meta_d;
  logic          din_s_q, din_s_d;
  logic          din_d_q, din_d_d;
  logic [CW-1:0] timer_q, timer_d;

  assign din_s = din_s_q;
  assign rise  = din_s_q & ~din_d_q;
  assign fall  = ~din_s_q & din_d_q;
  assign timer = timer_q;
  assign width = (timer_q == '1) ? timer_q : timer_q + CW'(1);

  always_comb begin
    din_meta_d = din;
    din_s_d    = din_meta_q;
    din_d_d    = din_s_q;
    timer_d    = timer_q;
    if (rise || fall) begin
      timer_d = '0;
    end else if (timer_q != '1) begin
      timer_d = timer_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_meta_q <= 1'b0;
      din_s_q    <= 1'b0;
      din_d_q    <= 1'b0;
      timer_q    <= '0;
    end else begin
      din_meta_q <= din_meta_d;
      din_s_q    <= din_s_d;
      din_d_q    <= din_d_d;
      timer_q    <= timer_d;
    end
  end

endmodule

// File: rtl/ws2811_rx.sv
// WS2811 single-wire receiver: decodes high-pulse widths into bits, assembles
// 24-bit GRB pixels and detects the latch gap. With PASS=1 it behaves like an
// LED chip: keeps the first pixel of a frame and regenerates the rest on DOUT.
// Ports:
//   CLKIN, RESETN : clock, asynchronous active-low reset
//   DIN           : serial data in (asynchronous)
//   PIXEL         : last captured pixel {G,R,B}, first bit received in [23]
//   PIXEL_VALID   : one-cycle pulse when PIXEL updates
//   LATCH         : one-cycle pulse on a reset/latch gap
//   PIXCNT        : pixels decoded in the current frame (saturating)
//   DOUT          : regenerated stream (PASS=1), otherwise 0
//   ERR           : one-cycle pulse on any protocol error
//
// state | meaning
// ------+-----------------------------------------------------------
// SYNC  | after reset/error; waiting for TRESET low cycles, no decode
// IDLE  | line low between bits; watching for a rise or a latch gap
// HIGH  | measuring a high pulse; decides the bit at the fall
module ws2811_rx
  import ws2811_pkg::*;
#(
  parameter int TH_MIN = 2,
  parameter int T1_MIN = 7,
  parameter int TH_MAX = 15,
  parameter int TRESET = 64,
  parameter int PASS   = 1,
  parameter int CW     = 8
) (
  input  logic             CLKIN,
  input  logic             RESETN,
  input  logic             DIN,
  output logic [PIX_W-1:0] PIXEL,
  output logic             PIXEL_VALID,
  output logic             LATCH,
  output logic [7:0]       PIXCNT,
  output logic             DOUT,
  output logic             ERR
);

  localparam logic [CW-1:0]   TH_MIN_C = CW'(TH_MIN);
  localparam logic [CW-1:0]   T1_MIN_C = CW'(T1_MIN);
  localparam logic [CW-1:0]   TH_MAX_C = CW'(TH_MAX);
  localparam logic [CW-1:0]   TRESET_C = CW'(TRESET);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(PIX_W - 1);

  logic          din_s, rise, fall;
  logic [CW-1:0] timer, width;

  ws2811_pulse_meas #(.CW(CW)) u_meas (
    .clk   (CLKIN),
    .rst_n (RESETN),
    .din   (DIN),
    .din_s (din_s),
    .rise  (rise),
    .fall  (fall),
    .timer (timer),
    .width (width)
  );

  rx_state_e        state_q, state_d;
  logic [PIX_W-1:0] shift_q, shift_d;
  logic [PIX_W-1:0] pixel_q, pixel_d;
  logic [BC_W-1:0]  bitcnt_q, bitcnt_d;
  logic [7:0]       pixcnt_q, pixcnt_d;
  logic             pv_q, pv_d;
  logic             latch_q, latch_d;
  logic             err_q, err_d;
  logic             fwd_q, fwd_d;
  logic             dout_q, dout_d;
  logic             bit_val;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    pixel_d  = pixel_q;
    bitcnt_d = bitcnt_q;
    // PIXCNT shows the frame total during the LATCH pulse, then clears.
    pixcnt_d = latch_q ? 8'd0 : pixcnt_q;
    pv_d     = 1'b0;
    latch_d  = 1'b0;
    err_d    = 1'b0;
    fwd_d    = fwd_q;
    bit_val  = (width >= T1_MIN_C);

    case (state_q)
      SYNC: begin
        if (!din_s && width >= TRESET_C) state_d = IDLE;
      end
      IDLE: begin
        if (rise) begin
          state_d = HIGH;
        end else if (!din_s && width == TRESET_C) begin
          // Equality keeps this to one LATCH per gap while the timer saturates.
          latch_d  = 1'b1;
          bitcnt_d = '0;
          shift_d  = '0;
          fwd_d    = 1'b0;
          if (bitcnt_q != '0) err_d = 1'b1;
        end
      end
      HIGH: begin
        if ((din_s && timer > TH_MAX_C) || (fall && width > TH_MAX_C)) begin
          err_d    = 1'b1;
          state_d  = SYNC;
          bitcnt_d = '0;
          shift_d  = '0;
          fwd_d    = 1'b0;
        end else if (fall) begin
          state_d = IDLE;
          if (width < TH_MIN_C) begin
            // Glitch: report it but keep the bits already collected.
            err_d = 1'b1;
            fwd_d = 1'b0;
          end else begin
            shift_d = {shift_q[PIX_W-2:0], bit_val};
            if (bitcnt_q == LAST_BIT) begin
              bitcnt_d = '0;
              pixcnt_d = (pixcnt_q == 8'hFF) ? pixcnt_q : pixcnt_q + 8'd1;
              if (PASS == 0 || !fwd_q) begin
                pixel_d = shift_d;
                pv_d    = 1'b1;
              end
              // Decision happens while the line is low, so forwarding never
              // starts in the middle of a pulse.
              if (PASS != 0) fwd_d = 1'b1;
            end else begin
              bitcnt_d = bitcnt_q + BC_W'(1);
            end
          end
        end
      end
      default: state_d = SYNC;
    endcase

    // Using fwd_d lets DOUT drop on the same cycle the forward flag clears.
    dout_d = (PASS != 0) ? (din_s & fwd_d) : 1'b0;
  end

  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      state_q  <= SYNC;
      shift_q  <= '0;
      pixel_q  <= '0;
      bitcnt_q <= '0;
      pixcnt_q <= '0;
      pv_q     <= 1'b0;
      latch_q  <= 1'b0;
      err_q    <= 1'b0;
      fwd_q    <= 1'b0;
      dout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      pixel_q  <= pixel_d;
      bitcnt_q <= bitcnt_d;
      pixcnt_q <= pixcnt_d;
      pv_q     <= pv_d;
      latch_q  <= latch_d;
      err_q    <= err_d;
      fwd_q    <= fwd_d;
      dout_q   <= dout_d;
    end
  end

  assign PIXEL       = pixel_q;
  assign PIXEL_VALID = pv_q;
  assign LATCH       = latch_q;
  assign PIXCNT      = pixcnt_q;
  assign DOUT        = dout_q;
  assign ERR         = err_q;

endmodule

// File: tb/tb_ws2811_rx.sv
// Bench for ws2811_rx: one PASS=1 and one PASS=0 instance share the line.
module tb_ws2811_rx;
  import ws2811_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0;

  logic [23:0] pix_p, pix_n;
  logic        pv_p, pv_n, la_p, la_n, dout_p, dout_n, err_p, err_n;
  logic [7:0]  cnt_p, cnt_n;

  ws2811_rx #(.PASS(1)) u_pass (
    .CLKIN(clk), .RESETN(rst_n), .DIN(din), .PIXEL(pix_p), .PIXEL_VALID(pv_p),
    .LATCH(la_p), .PIXCNT(cnt_p), .DOUT(dout_p), .ERR(err_p));

  ws2811_rx #(.PASS(0)) u_nopass (
    .CLKIN(clk), .RESETN(rst_n), .DIN(din), .PIXEL(pix_n), .PIXEL_VALID(pv_n),
    .LATCH(la_n), .PIXCNT(cnt_n), .DOUT(dout_n), .ERR(err_n));

  always #5 clk = ~clk;

  typedef struct { logic [7:0] cnt; logic err; } lat_t;
  typedef struct { int hi; logic exp_err; logic exp_bit; } wvec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_fall_cyc = 0;
  int pv_cyc_p = 0, pv_cyc_n = 0;
  int nerr_p = 0, nerr_n = 0;
  logic fwd_exp = 1'b0;
  logic [23:0] q_pix_p[$], q_pix_n[$];
  lat_t q_lat_p[$], q_lat_n[$];
  wvec_t wv[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard, sampled 2 time units after each rising edge.
  logic d1 = 1'b0, d2 = 1'b0, f1 = 1'b0, f2 = 1'b0;
  logic lat_prev_p = 1'b0, lat_prev_n = 1'b0;
  always @(posedge clk) begin
    cyc++;
    #2;
    if (!rst_n) begin
      d1 = 1'b0; d2 = 1'b0; f1 = 1'b0; f2 = 1'b0;
      lat_prev_p = 1'b0; lat_prev_n = 1'b0;
    end else begin
      if (pv_p) begin
        pv_cyc_p = cyc;
        chk("pv_p_expected", 32'(q_pix_p.size() != 0), 32'd1);
        if (q_pix_p.size() != 0) chk("pixel_p", 32'(pix_p), 32'(q_pix_p.pop_front()));
      end
      if (pv_n) begin
        pv_cyc_n = cyc;
        chk("pv_n_expected", 32'(q_pix_n.size() != 0), 32'd1);
        if (q_pix_n.size() != 0) chk("pixel_n", 32'(pix_n), 32'(q_pix_n.pop_front()));
      end
      if (lat_prev_p) chk("pixcnt_clr_p", 32'(cnt_p), 32'd0);
      if (lat_prev_n) chk("pixcnt_clr_n", 32'(cnt_n), 32'd0);
      if (la_p) begin
        chk("latch_p_expected", 32'(q_lat_p.size() != 0), 32'd1);
        if (q_lat_p.size() != 0) begin
          lat_t e;
          e = q_lat_p.pop_front();
          chk("latch_cnt_p", 32'(cnt_p), 32'(e.cnt));
          chk("latch_err_p", 32'(err_p), 32'(e.err));
        end
      end
      if (la_n) begin
        chk("latch_n_expected", 32'(q_lat_n.size() != 0), 32'd1);
        if (q_lat_n.size() != 0) begin
          lat_t e;
          e = q_lat_n.pop_front();
          chk("latch_cnt_n", 32'(cnt_n), 32'(e.cnt));
          chk("latch_err_n", 32'(err_n), 32'(e.err));
        end
      end
      lat_prev_p = la_p;
      lat_prev_n = la_n;
      if (err_p) nerr_p++;
      if (err_n) nerr_n++;
      chk("dout_p", 32'(dout_p), 32'(d2 & f2));
      chk("dout_n", 32'(dout_n), 32'd0);
      d2 = d1; f2 = f1;
      d1 = din; f1 = fwd_exp;
    end
  end

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      @(negedge clk);
      din = v;
    end
  endtask

  task automatic send_pulse(input int hi, input int lo);
    drive(1'b1, hi);
    @(negedge clk);
    din = 1'b0;
    last_fall_cyc = cyc;
    if (lo > 1) drive(1'b0, lo - 1);
  endtask

  task automatic send_bit(input logic b);
    if (b) send_pulse(T1H, BIT_TICKS - T1H);
    else   send_pulse(T0H, BIT_TICKS - T0H);
  endtask

  task automatic send_pix(input logic [23:0] p);
    for (int i = 23; i >= 0; i--) send_bit(p[i]);
  endtask

  task automatic expect_latch(input logic [7:0] c, input logic e);
    lat_t l;
    l.cnt = c;
    l.err = e;
    q_lat_p.push_back(l);
    q_lat_n.push_back(l);
  endtask

  task automatic expect_pix(input logic [23:0] p, input logic to_pass);
    if (to_pass) q_pix_p.push_back(p);
    q_pix_n.push_back(p);
  endtask

  initial begin
    logic [23:0] base;
    logic [23:0] exp_pix;
    logic [23:0] stream[3];
    int e0p, e0n;

    wv[0] = '{hi: 1,  exp_err: 1'b1, exp_bit: 1'b0};
    wv[1] = '{hi: 2,  exp_err: 1'b0, exp_bit: 1'b0};
    wv[2] = '{hi: 6,  exp_err: 1'b0, exp_bit: 1'b0};
    wv[3] = '{hi: 7,  exp_err: 1'b0, exp_bit: 1'b1};
    wv[4] = '{hi: 15, exp_err: 1'b0, exp_bit: 1'b1};
    base = 24'hC35A96;
    stream[0] = 24'h112233;
    stream[1] = 24'h445566;
    stream[2] = 24'h778899;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pixel_p", 32'(pix_p), 32'd0);
    chk("rst_pv_p", 32'(pv_p), 32'd0);
    chk("rst_latch_p", 32'(la_p), 32'd0);
    chk("rst_cnt_p", 32'(cnt_p), 32'd0);
    chk("rst_dout_p", 32'(dout_p), 32'd0);
    chk("rst_err_p", 32'(err_p), 32'd0);
    chk("rst_pixel_n", 32'(pix_n), 32'd0);
    chk("rst_cnt_n", 32'(cnt_n), 32'd0);
    rst_n = 1'b1;

    // Power-up: 64 low cycles leave SYNC silently, then one pixel.
    drive(1'b0, 64);
    expect_pix(24'h0FA53C, 1'b1);
    send_pix(24'h0FA53C);
    drive(1'b0, 6);
    chk("pv_latency_p", 32'(pv_cyc_p - last_fall_cyc), 32'd3);
    chk("pv_latency_n", 32'(pv_cyc_n - last_fall_cyc), 32'd3);
    chk("pixcnt_pwrup_p", 32'(cnt_p), 32'd1);
    chk("pixcnt_pwrup_n", 32'(cnt_n), 32'd1);
    expect_latch(8'd1, 1'b0);
    drive(1'b0, 70);

    // Pulse-width boundaries applied to the last bit of a pixel.
    for (int i = 0; i < 5; i++) begin
      exp_pix = {base[23:1], (wv[i].exp_err ? 1'b1 : wv[i].exp_bit)};
      e0p = nerr_p;
      e0n = nerr_n;
      expect_pix(exp_pix, 1'b1);
      for (int b = 23; b >= 1; b--) send_bit(base[b]);
      send_pulse(wv[i].hi, 16 - wv[i].hi);
      if (wv[i].exp_err) send_bit(1'b1);
      drive(1'b0, 6);
      chk("width_err_p", 32'(nerr_p - e0p), 32'(wv[i].exp_err));
      chk("width_err_n", 32'(nerr_n - e0n), 32'(wv[i].exp_err));
      expect_latch(8'd1, 1'b0);
      drive(1'b0, 70);
    end

    // Three-pixel frame: PASS=1 keeps the first and forwards the rest.
    expect_pix(stream[0], 1'b1);
    expect_pix(stream[1], 1'b0);
    expect_pix(stream[2], 1'b0);
    send_pix(stream[0]);
    fwd_exp = 1'b1;
    send_pix(stream[1]);
    send_pix(stream[2]);
    drive(1'b0, 6);
    chk("pixcnt3_p", 32'(cnt_p), 32'd3);
    chk("pixcnt3_n", 32'(cnt_n), 32'd3);
    expect_latch(8'd3, 1'b0);
    drive(1'b0, 70);
    fwd_exp = 1'b0;
    chk("pass_pixel_kept", 32'(pix_p), 32'h112233);
    chk("nopass_pixel_last", 32'(pix_n), 32'h778899);

    // Glitch in the middle of a pixel: flagged, not counted.
    e0p = nerr_p;
    e0n = nerr_n;
    exp_pix = 24'h3C5AA5;
    expect_pix(exp_pix, 1'b1);
    for (int b = 23; b >= 14; b--) send_bit(exp_pix[b]);
    send_pulse(1, 15);
    for (int b = 13; b >= 0; b--) send_bit(exp_pix[b]);
    drive(1'b0, 6);
    chk("glitch_err_p", 32'(nerr_p - e0p), 32'd1);
    chk("glitch_err_n", 32'(nerr_n - e0n), 32'd1);
    expect_latch(8'd1, 1'b0);
    drive(1'b0, 70);

    // Stuck high: one ERR, then a bit sent inside the resync gap is ignored.
    e0p = nerr_p;
    e0n = nerr_n;
    drive(1'b1, 20);
    drive(1'b0, 40);
    send_bit(1'b1);
    drive(1'b0, 70);
    chk("stuck_err_p", 32'(nerr_p - e0p), 32'd1);
    chk("stuck_err_n", 32'(nerr_n - e0n), 32'd1);
    expect_pix(24'hA1B2C3, 1'b1);
    send_pix(24'hA1B2C3);
    expect_latch(8'd1, 1'b0);
    drive(1'b0, 76);

    // Partial frame: LATCH with ERR, PIXEL untouched.
    e0p = nerr_p;
    e0n = nerr_n;
    for (int b = 0; b < 10; b++) send_bit(1'b1);
    expect_latch(8'd0, 1'b1);
    drive(1'b0, 76);
    chk("partial_err_p", 32'(nerr_p - e0p), 32'd1);
    chk("partial_err_n", 32'(nerr_n - e0n), 32'd1);
    chk("partial_pix_p", 32'(pix_p), 32'hA1B2C3);
    chk("partial_pix_n", 32'(pix_n), 32'hA1B2C3);

    // Reset in the middle of a pixel.
    expect_pix(24'h5AC3E1, 1'b1);
    send_pix(24'h5AC3E1);
    fwd_exp = 1'b1;
    for (int b = 0; b < 8; b++) send_bit(1'b1);
    chk("pre_rst_cnt_p", 32'(cnt_p), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    din = 1'b0;
    fwd_exp = 1'b0;
    #1;
    chk("mid_rst_pixel_p", 32'(pix_p), 32'd0);
    chk("mid_rst_pixel_n", 32'(pix_n), 32'd0);
    chk("mid_rst_cnt_p", 32'(cnt_p), 32'd0);
    chk("mid_rst_cnt_n", 32'(cnt_n), 32'd0);
    chk("mid_rst_pv_p", 32'(pv_p), 32'd0);
    chk("mid_rst_latch_p", 32'(la_p), 32'd0);
    chk("mid_rst_err_p", 32'(err_p), 32'd0);
    chk("mid_rst_dout_p", 32'(dout_p), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 5);

    chk("pix_q_p_empty", 32'(q_pix_p.size()), 32'd0);
    chk("pix_q_n_empty", 32'(q_pix_n.size()), 32'd0);
    chk("lat_q_p_empty", 32'(q_lat_p.size()), 32'd0);
    chk("lat_q_n_empty", 32'(q_lat_n.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
